// File: rtl/accelerator_x_serializer_pkg.sv
// Shared types and helpers for the X-operand serializer.
// State encodings stay plain 2-bit constants so older tools can consume them.
package accelerator_x_serializer_pkg;

    typedef logic [1:0] x_ser_state_e;

    localparam x_ser_state_e X_SER_IDLE = 2'd0;
    localparam x_ser_state_e X_SER_RUN  = 2'd1;
    localparam x_ser_state_e X_SER_DONE = 2'd2;

    function automatic int unsigned x_items_cycle(
        input int unsigned bw,
        input int unsigned item_size
    );
        return bw / item_size;
    endfunction

    function automatic int unsigned lane_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/accelerator_x_serializer_if.sv
// Beat stream carrying packed X items from the streamer.
// Master drives data/strb/valid, slave returns ready.
interface accelerator_x_serializer_if #(
    parameter int unsigned DATA_WIDTH = 256
);
    logic                      valid;
    logic                      ready;
    logic [DATA_WIDTH-1:0]     data;
    logic [DATA_WIDTH/8-1:0]   strb;

    modport master (
        output valid, data, strb,
        input  ready
    );

    modport slave (
        input  valid, data, strb,
        output ready
    );
endinterface

// File: rtl/accelerator_x_lane_mux.sv
// Combinational selection of one X item (and its strobes) out of a beat.
// Strobe path exists only with ACC_X_SER_STRB_CHECK_EN defined.
module accelerator_x_lane_mux
    import accelerator_x_serializer_pkg::*;
#(
    parameter int unsigned BW          = 256,
    parameter int unsigned X_ITEM_SIZE = 8,
    localparam int unsigned XIC        = x_items_cycle(BW, X_ITEM_SIZE),
    localparam int unsigned ISB        = X_ITEM_SIZE / 8,
    localparam int unsigned LANE_W     = lane_w(XIC)
) (
    input  logic [BW-1:0]          i_data,
`ifdef ACC_X_SER_STRB_CHECK_EN
    input  logic [BW/8-1:0]        i_strb,
    output logic [ISB-1:0]         o_strb,
`endif
    input  logic [LANE_W-1:0]      i_lane,
    output logic [X_ITEM_SIZE-1:0] o_item
);
    logic [XIC-1:0][X_ITEM_SIZE-1:0] w_lanes;

    assign w_lanes = i_data;
    assign o_item  = w_lanes[i_lane];

`ifdef ACC_X_SER_STRB_CHECK_EN
    logic [XIC-1:0][ISB-1:0] w_strbs;

    assign w_strbs = i_strb;
    assign o_strb  = w_strbs[i_lane];
`endif
endmodule

// File: rtl/accelerator_x_serializer.sv
// Splits BW-wide X beats into single items tagged with column/row-last/stream-last.
// Optional strobe checking and err_o output: ACC_X_SER_STRB_CHECK_EN.
module accelerator_x_serializer
    import accelerator_x_serializer_pkg::*;
#(
    parameter int unsigned BW            = 256,
    parameter int unsigned X_ITEM_SIZE   = 8,
    parameter int unsigned MAX_X_COLUMNS = 1024,
    parameter int unsigned CNT_W         = 32,
    localparam int unsigned COL_W        = $clog2(MAX_X_COLUMNS),
    localparam int unsigned XIC          = x_items_cycle(BW, X_ITEM_SIZE),
    localparam int unsigned ISB          = X_ITEM_SIZE / 8,
    localparam int unsigned LANE_W       = lane_w(XIC)
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   clear_i,
    input  logic                   start_i,
    input  logic [COL_W:0]         x_columns_i,
    input  logic [CNT_W-1:0]       total_rows_i,
    accelerator_x_serializer_if.slave x_i,
    output logic                   item_valid_o,
    input  logic                   item_ready_i,
    output logic [X_ITEM_SIZE-1:0] item_data_o,
    output logic [COL_W-1:0]       item_col_o,
    output logic                   item_row_last_o,
    output logic                   item_stream_last_o,
    output logic                   busy_o,
`ifdef ACC_X_SER_STRB_CHECK_EN
    output logic                   err_o,
`endif
    output logic                   done_o
);
    x_ser_state_e           r_state;
    logic [BW-1:0]          r_buf;
    logic                   r_buf_vld;
    logic [LANE_W-1:0]      r_lane;
    logic [COL_W-1:0]       r_col;
    logic [CNT_W-1:0]       r_row;
    logic [CNT_W-1:0]       r_rows;
    logic [COL_W:0]         r_xcols;

    logic                   w_run;
    logic                   w_hs;
    logic                   w_row_last;
    logic                   w_stream_last;
    logic                   w_last_lane;
    logic                   w_release;
    logic                   w_beat;
    logic [X_ITEM_SIZE-1:0] w_item;

    assign w_run         = (r_state == X_SER_RUN);
    assign item_valid_o  = w_run && r_buf_vld;
    assign w_hs          = item_valid_o && item_ready_i;
    assign w_row_last    = ({1'b0, r_col} == r_xcols - 1'b1);
    assign w_stream_last = w_row_last && (r_row == r_rows - 1'b1);
    assign w_last_lane   = (r_lane == LANE_W'(XIC - 1));
    assign w_release     = w_hs && (w_last_lane || w_row_last);

    // Refill in the same cycle the buffer drains, but never past the final item.
    assign x_i.ready = w_run && !clear_i &&
                       (!r_buf_vld || (w_release && !w_stream_last));
    assign w_beat    = x_i.valid && x_i.ready;

    assign item_data_o        = item_valid_o ? w_item : '0;
    assign item_col_o         = item_valid_o ? r_col : '0;
    assign item_row_last_o    = item_valid_o && w_row_last;
    assign item_stream_last_o = item_valid_o && w_stream_last;
    assign busy_o             = w_run;
    assign done_o             = (r_state == X_SER_DONE);

    accelerator_x_lane_mux #(
        .BW          (BW),
        .X_ITEM_SIZE (X_ITEM_SIZE)
    ) u_lane_mux (
        .i_data (r_buf),
`ifdef ACC_X_SER_STRB_CHECK_EN
        .i_strb (r_strb),
        .o_strb (w_item_strb),
`endif
        .i_lane (r_lane),
        .o_item (w_item)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state   <= X_SER_IDLE;
            r_buf     <= '0;
            r_buf_vld <= 1'b0;
            r_lane    <= '0;
            r_col     <= '0;
            r_row     <= '0;
            r_rows    <= '0;
            r_xcols   <= '0;
        end else if (clear_i) begin
            r_state   <= X_SER_IDLE;
            r_buf     <= '0;
            r_buf_vld <= 1'b0;
            r_lane    <= '0;
            r_col     <= '0;
            r_row     <= '0;
            r_rows    <= '0;
            r_xcols   <= '0;
        end else begin
            unique case (1'b1)
                (r_state == X_SER_IDLE): begin
                    if (start_i) begin
                        r_xcols <= x_columns_i;
                        r_rows  <= total_rows_i;
                        r_col   <= '0;
                        r_row   <= '0;
                        r_state <= (total_rows_i != '0) ? X_SER_RUN
                                                        : X_SER_DONE;
                    end
                end
                (r_state == X_SER_RUN): begin
                    if (w_beat) begin
                        r_buf     <= x_i.data;
                        r_buf_vld <= 1'b1;
                        r_lane    <= '0;
                    end else if (w_release) begin
                        r_buf_vld <= 1'b0;
                    end else if (w_hs) begin
                        r_lane <= r_lane + 1'b1;
                    end
                    if (w_hs) begin
                        if (w_row_last) begin
                            r_col <= '0;
                            r_row <= r_row + 1'b1;
                        end else begin
                            r_col <= r_col + 1'b1;
                        end
                        if (w_stream_last) begin
                            r_state <= X_SER_DONE;
                        end
                    end
                end
                default: r_state <= X_SER_IDLE;
            endcase
        end
    end

`ifdef ACC_X_SER_STRB_CHECK_EN
    logic [BW/8-1:0] r_strb;
    logic [ISB-1:0]  w_item_strb;
    logic [BW/8-1:0] w_tail_strb;
    logic            r_err;

    // Strobes above the last lane this beat actually delivered.
    assign w_tail_strb = r_strb >> (ISB * (32'(r_lane) + 32'd1));
    assign err_o       = r_err;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_strb <= '0;
            r_err  <= 1'b0;
        end else if (clear_i) begin
            r_strb <= '0;
            r_err  <= 1'b0;
        end else begin
            if (w_beat) begin
                r_strb <= x_i.strb;
            end
            if (w_hs && ((w_item_strb != '1) ||
                         (w_release && (w_tail_strb != '0)))) begin
                r_err <= 1'b1;
            end
        end
    end
`endif
endmodule

// File: tb/tb_accelerator_x_serializer.sv
// Randomized self-checking bench for accelerator_x_serializer (BW=64, 8-bit items).
// Items are predicted from beat contents and row geometry alone.
module tb_accelerator_x_serializer;
    localparam int BW   = 64;
    localparam int XS   = 8;
    localparam int XIC  = BW / XS;
    localparam int MAXC = 1024;
    localparam int COLW = 10;
    localparam int CNTW = 32;

    logic             clk = 1'b0;
    logic             rst_ni = 1'b0;
    logic             clear_i = 1'b0;
    logic             start_i = 1'b0;
    logic [COLW:0]    x_columns_i = '0;
    logic [CNTW-1:0]  total_rows_i = '0;
    logic             item_valid_o;
    logic             item_ready_i = 1'b0;
    logic [XS-1:0]    item_data_o;
    logic [COLW-1:0]  item_col_o;
    logic             item_row_last_o;
    logic             item_stream_last_o;
    logic             busy_o;
    logic             done_o;
`ifdef ACC_X_SER_STRB_CHECK_EN
    logic             err_o;
`endif

    accelerator_x_serializer_if #(.DATA_WIDTH(BW)) x_if ();

    accelerator_x_serializer #(
        .BW            (BW),
        .X_ITEM_SIZE   (XS),
        .MAX_X_COLUMNS (MAXC),
        .CNT_W         (CNTW)
    ) dut (
        .clk_i              (clk),
        .rst_ni             (rst_ni),
        .clear_i            (clear_i),
        .start_i            (start_i),
        .x_columns_i        (x_columns_i),
        .total_rows_i       (total_rows_i),
        .x_i                (x_if),
        .item_valid_o       (item_valid_o),
        .item_ready_i       (item_ready_i),
        .item_data_o        (item_data_o),
        .item_col_o         (item_col_o),
        .item_row_last_o    (item_row_last_o),
        .item_stream_last_o (item_stream_last_o),
        .busy_o             (busy_o),
`ifdef ACC_X_SER_STRB_CHECK_EN
        .err_o              (err_o),
`endif
        .done_o             (done_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [BW-1:0] d;
        logic [7:0]    s;
    } beat_t;

    typedef struct {
        logic [7:0] d;
        int         col;
        bit         rl;
        bit         sl;
        bit         bad;
    } exp_t;

    beat_t src_q[$];
    exp_t  exp_q[$];
    int    nchk = 0;
    int    nfail = 0;
    bit    exp_err = 1'b0;

    function automatic beat_t rnd_beat();
        beat_t b;
        b.d = {$urandom(), $urandom()};
        b.s = 8'hFF;
        return b;
    endfunction

    function automatic beat_t seq_beat(int base);
        beat_t b;
        for (int k = 0; k < XIC; k++) b.d[k*8 +: 8] = 8'(base + k);
        b.s = 8'hFF;
        return b;
    endfunction

    // Reference: rows start on a fresh beat, item c of a row sits in lane c mod XIC.
    task automatic build_expected(input int xcols, input int rows,
                                  output int nbeats);
        int    bi = 0;
        int    lane;
        bit    rel;
        beat_t cur;
        exp_t  e;
        cur.d = '0;
        cur.s = '0;
        for (int r = 0; r < rows; r++) begin
            for (int c = 0; c < xcols; c++) begin
                lane = c % XIC;
                if (lane == 0) begin
                    cur = src_q[bi];
                    bi++;
                end
                e.d   = cur.d[lane*8 +: 8];
                e.col = c;
                e.rl  = (c == xcols - 1);
                e.sl  = e.rl && (r == rows - 1);
                rel   = (lane == XIC - 1) || e.rl;
                e.bad = !cur.s[lane] || (rel && ((cur.s >> (lane + 1)) != 0));
                exp_q.push_back(e);
            end
        end
        nbeats = bi;
    endtask

    task automatic run_stream(input string nm, input int xcols, input int rows,
                              input int lowpct, input int stop_at,
                              input int bound);
        int   nb, n, got, taken, cyc, first, lastc;
        bit   stall;
        logic [XS+COLW+1:0] prev;
        exp_t e;
        got = 0; taken = 0; cyc = 0; first = -1; lastc = -1;
        stall = 1'b0; prev = '0;
        build_expected(xcols, rows, nb);
        n = exp_q.size();
        item_ready_i = 1'b0;
        x_if.valid   = 1'b0;
        start_i      = 1'b1;
        x_columns_i  = (COLW+1)'(xcols);
        total_rows_i = CNTW'(rows);
        @(posedge clk); #1;
        start_i = 1'b0;
        while (got < n && cyc < bound) begin
            item_ready_i = ($urandom_range(99) >= lowpct);
            if (src_q.size() > 0) begin
                x_if.valid = 1'b1;
                x_if.data  = src_q[0].d;
                x_if.strb  = src_q[0].s;
            end else begin
                x_if.valid = 1'b0;
            end
            #1;
            if (stall) begin
                nchk++;
                if (!item_valid_o || {item_data_o, item_col_o, item_row_last_o,
                                      item_stream_last_o} !== prev) begin
                    nfail++;
                    $display("FAIL %s hold cyc%0d got v=%b %h want v=1 %h", nm,
                             cyc, item_valid_o, {item_data_o, item_col_o,
                             item_row_last_o, item_stream_last_o}, prev);
                end
            end
`ifdef ACC_X_SER_STRB_CHECK_EN
            nchk++;
            if (err_o !== exp_err) begin
                nfail++;
                $display("FAIL %s err cyc%0d got %b want %b", nm, cyc, err_o,
                         exp_err);
            end
`endif
            if (x_if.valid && x_if.ready) begin
                void'(src_q.pop_front());
                taken++;
            end
            if (item_valid_o && item_ready_i) begin
                e = exp_q.pop_front();
                nchk++;
                if ({item_data_o, item_col_o, item_row_last_o, item_stream_last_o}
                    !== {e.d, COLW'(e.col), e.rl, e.sl}) begin
                    nfail++;
                    $display("FAIL %s item%0d got d=%h col=%0d rl=%b sl=%b want d=%h col=%0d rl=%b sl=%b",
                             nm, got, item_data_o, item_col_o, item_row_last_o,
                             item_stream_last_o, e.d, e.col, e.rl, e.sl);
                end
                if (e.bad) exp_err = 1'b1;
                if (first < 0) first = cyc;
                lastc = cyc;
                got++;
            end
            stall = item_valid_o && !item_ready_i;
            prev  = {item_data_o, item_col_o, item_row_last_o, item_stream_last_o};
            if (stop_at != 0 && got == stop_at) return;
            @(posedge clk); #1;
            cyc++;
        end
        nchk++;
        if (got < n) begin
            nfail++;
            $display("FAIL %s timeout items got %0d want %0d", nm, got, n);
        end
        if (src_q.size() > 0) begin
            x_if.valid = 1'b1;
            x_if.data  = src_q[0].d;
            x_if.strb  = src_q[0].s;
        end
        #1;
        nchk++;
        if ({done_o, busy_o, item_valid_o, x_if.ready} !== 4'b1000) begin
            nfail++;
            $display("FAIL %s done_cycle got done/busy/v/rdy=%b want 1000", nm,
                     {done_o, busy_o, item_valid_o, x_if.ready});
        end
        @(posedge clk); #2;
        nchk++;
        if ({done_o, busy_o, x_if.ready} !== 3'b000) begin
            nfail++;
            $display("FAIL %s after_done got done/busy/rdy=%b want 000", nm,
                     {done_o, busy_o, x_if.ready});
        end
        nchk++;
        if (taken != nb) begin
            nfail++;
            $display("FAIL %s beats got %0d want %0d", nm, taken, nb);
        end
        if (lowpct == 0) begin
            nchk++;
            if (lastc - first != n - 1) begin
                nfail++;
                $display("FAIL %s bubble span got %0d want %0d", nm,
                         lastc - first, n - 1);
            end
        end
        x_if.valid = 1'b0;
        src_q.delete();
        exp_q.delete();
    endtask

    task automatic test_reset();
        #2;
        nchk++;
        if ({item_valid_o, item_data_o, item_col_o, item_row_last_o,
             item_stream_last_o, busy_o, done_o, x_if.ready} !== '0) begin
            nfail++;
            $display("FAIL reset outputs got v=%b d=%h col=%0d busy=%b done=%b rdy=%b want 0",
                     item_valid_o, item_data_o, item_col_o, busy_o, done_o,
                     x_if.ready);
        end
`ifdef ACC_X_SER_STRB_CHECK_EN
        nchk++;
        if (err_o !== 1'b0) begin
            nfail++;
            $display("FAIL reset err got %b want 0", err_o);
        end
`endif
        @(negedge clk);
        rst_ni = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        src_q.push_back(seq_beat(0));
        src_q.push_back(seq_beat(8));
        src_q.push_back(rnd_beat());
        run_stream("basic", 8, 2, 0, 0, 200);
    endtask

    task automatic test_partial();
        beat_t b;
        src_q.push_back(rnd_beat());
        b = rnd_beat();
        b.s = 8'h03;
        src_q.push_back(b);
        src_q.push_back(rnd_beat());
        run_stream("partial", 10, 1, 0, 0, 200);
    endtask

    task automatic test_backpressure();
        src_q.push_back(seq_beat(0));
        src_q.push_back(seq_beat(8));
        src_q.push_back(rnd_beat());
        run_stream("backpressure", 8, 2, 30, 0, 400);
    endtask

    task automatic test_random();
        int xc, rw, nb;
        for (int it = 0; it < 4; it++) begin
            xc = $urandom_range(20, 1);
            rw = $urandom_range(3, 1);
            nb = rw * ((xc + XIC - 1) / XIC);
            for (int k = 0; k <= nb; k++) src_q.push_back(rnd_beat());
            run_stream("random", xc, rw, 20, 0, 600);
        end
    endtask

    task automatic test_zero_rows();
        int rdy_cnt = 0, dcnt = 0, dcyc = -1;
        x_if.valid   = 1'b1;
        x_if.data    = 64'h1122334455667788;
        x_if.strb    = 8'hFF;
        start_i      = 1'b1;
        x_columns_i  = 11'd4;
        total_rows_i = '0;
        for (int i = 0; i < 6; i++) begin
            #1;
            if (x_if.ready) rdy_cnt++;
            if (done_o) begin
                dcnt++;
                dcyc = i;
            end
            @(posedge clk); #1;
            if (i == 0) start_i = 1'b0;
        end
        x_if.valid = 1'b0;
        nchk++;
        if (rdy_cnt != 0) begin
            nfail++;
            $display("FAIL zero_rows ready got %0d cycles want 0", rdy_cnt);
        end
        nchk++;
        if (dcnt != 1 || dcyc != 1) begin
            nfail++;
            $display("FAIL zero_rows done got %0d pulses at %0d want 1 at 1",
                     dcnt, dcyc);
        end
    endtask

    task automatic test_clear();
        src_q.push_back(seq_beat(0));
        src_q.push_back(seq_beat(8));
        run_stream("clear_pre", 8, 2, 0, 5, 200);
        clear_i = 1'b1;
        @(posedge clk); #1;
        clear_i    = 1'b0;
        x_if.valid = 1'b0;
        #1;
        nchk++;
        if ({item_valid_o, item_data_o, item_col_o, item_row_last_o,
             item_stream_last_o, busy_o, done_o, x_if.ready} !== '0) begin
            nfail++;
            $display("FAIL clear outputs got v=%b d=%h col=%0d busy=%b done=%b rdy=%b want 0",
                     item_valid_o, item_data_o, item_col_o, busy_o, done_o,
                     x_if.ready);
        end
        src_q.delete();
        exp_q.delete();
        exp_err = 1'b0;
        src_q.push_back(seq_beat(32));
        src_q.push_back(rnd_beat());
        run_stream("clear_post", 4, 1, 0, 0, 200);
    endtask

    task automatic test_async_reset();
        src_q.push_back(seq_beat(64));
        src_q.push_back(seq_beat(72));
        run_stream("areset_pre", 8, 2, 0, 3, 200);
        #1;
        rst_ni = 1'b0;
        #1;
        nchk++;
        if ({item_valid_o, item_data_o, item_col_o, busy_o, done_o,
             x_if.ready} !== '0) begin
            nfail++;
            $display("FAIL async_reset got v=%b d=%h col=%0d busy=%b done=%b rdy=%b want 0",
                     item_valid_o, item_data_o, item_col_o, busy_o, done_o,
                     x_if.ready);
        end
        x_if.valid = 1'b0;
        src_q.delete();
        exp_q.delete();
        exp_err = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_ni = 1'b1;
        @(posedge clk); #1;
        src_q.push_back(seq_beat(100));
        src_q.push_back(rnd_beat());
        run_stream("areset_post", 4, 1, 0, 0, 200);
    endtask

`ifdef ACC_X_SER_STRB_CHECK_EN
    task automatic test_strb_err();
        beat_t b;
        b = seq_beat(16);
        b.s = 8'hFB;
        src_q.push_back(b);
        src_q.push_back(rnd_beat());
        run_stream("strb", 8, 1, 0, 0, 200);
        nchk++;
        if (err_o !== 1'b1) begin
            nfail++;
            $display("FAIL strb sticky got %b want 1", err_o);
        end
        clear_i = 1'b1;
        @(posedge clk); #1;
        clear_i = 1'b0;
        exp_err = 1'b0;
        #1;
        nchk++;
        if (err_o !== 1'b0) begin
            nfail++;
            $display("FAIL strb cleared got %b want 0", err_o);
        end
    endtask
`endif

    initial begin
        x_if.valid = 1'b0;
        x_if.data  = '0;
        x_if.strb  = '0;
        test_reset();
        test_basic();
        test_partial();
        test_backpressure();
        test_zero_rows();
        test_clear();
        test_async_reset();
`ifdef ACC_X_SER_STRB_CHECK_EN
        test_strb_err();
`endif
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
